// File: rtl/risc_cpu_if.sv
// Memory bus between the accumulator core and its unified program/data store.
interface risc_cpu_if;
    logic [4:0] addr;
    logic [7:0] rdata;
    logic [7:0] wdata;
    logic       wr;

    modport master (output addr, output wdata, output wr, input rdata);
    modport slave  (input addr, input wdata, input wr, output rdata);
endinterface

// File: rtl/risc_cpu.sv
// 8-bit accumulator CPU: 8-state fetch/execute controller, ALU and a 32x8
// unified memory with combinational read and clocked write.
package risc_cpu_pkg;
    typedef enum logic [2:0] {
        OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
    } opcode_t;
endpackage

module risc_cpu_ctrl
    import risc_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  opcode_t    opcode,
    output logic [2:0] phase,
    output logic       sel,
    output logic       wr
);
    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
    } state_t;

    state_t state;
    state_t state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            INST_ADDR:  state_nxt = INST_FETCH;
            INST_FETCH: state_nxt = INST_LOAD;
            INST_LOAD:  state_nxt = IDLE;
            IDLE:       state_nxt = OP_ADDR;
            OP_ADDR:    state_nxt = (opcode == OP_HLT) ? OP_ADDR : OP_FETCH;
            OP_FETCH:   state_nxt = ALU_OP;
            ALU_OP:     state_nxt = STORE;
            STORE:      state_nxt = INST_ADDR;
            default:    state_nxt = INST_ADDR;
        endcase
    end

    // sel/wr are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INST_ADDR;
            sel   <= 1'b1;
            wr    <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= (state_nxt inside {INST_ADDR, INST_FETCH, INST_LOAD, IDLE});
            wr    <= (state_nxt == STORE) && (opcode == OP_STO);
        end
    end

    assign phase = state;
endmodule

module risc_cpu_alu
    import risc_cpu_pkg::*;
(
    input  opcode_t    opcode,
    input  logic [7:0] ac,
    input  logic [7:0] operand,
    output logic [7:0] out
);
    always_comb begin
        out = ac;
        unique case (opcode)
            OP_ADD:  out = ac + operand;
            OP_AND:  out = ac & operand;
            OP_XOR:  out = ac ^ operand;
            OP_LDA:  out = operand;
            default: out = ac;
        endcase
    end
endmodule

module risc_cpu_mem (
    input logic      clk,
    risc_cpu_if.slave bus
);
    logic [7:0] mem [0:31];

    always_ff @(posedge clk) begin
        if (bus.wr) mem[bus.addr] <= bus.wdata;
    end

    assign bus.rdata = mem[bus.addr];
endmodule

module risc_cpu
    import risc_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] data_out
);
    logic [4:0] pc;
    logic [4:0] addr;
    logic [7:0] ir;
    logic [7:0] ac;
    logic [7:0] mem_data;
    logic [7:0] alu_out;
    logic [2:0] phase;
    logic       wr;
    logic       sel;
    opcode_t    opcode;

    risc_cpu_if bus ();

    assign opcode    = opcode_t'(ir[7:5]);
    assign addr      = sel ? pc : ir[4:0];
    assign bus.addr  = addr;
    assign bus.wdata = ac;
    assign bus.wr    = wr;
    assign mem_data  = bus.rdata;
    assign data_out  = ac;

    risc_cpu_ctrl ctrl0 (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .phase  (phase),
        .sel    (sel),
        .wr     (wr)
    );

    risc_cpu_mem mem0 (
        .clk (clk),
        .bus (bus.slave)
    );

    risc_cpu_alu alu0 (
        .opcode  (opcode),
        .ac      (ac),
        .operand (mem_data),
        .out     (alu_out)
    );

    // The controller holds phase 4 on HLT, so the increment guard is what freezes PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
            ir <= '0;
            ac <= '0;
        end else begin
            unique case (phase)
                3'd2: ir <= mem_data;
                3'd4: if (opcode != OP_HLT) pc <= pc + 5'd1;
                3'd6: begin
                    if (opcode == OP_SKZ && ac == 8'h00) pc <= pc + 5'd1;
                    else if (opcode == OP_JMP)           pc <= ir[4:0];
                end
                3'd7: begin
                    if (opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA}) ac <= alu_out;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_cpu.sv
// Directed bench for risc_cpu: small hand-assembled programs with hand-computed results.
module tb_risc_cpu;
    logic       clk;
    logic       rst;
    logic [7:0] data_out;
    int         checks;
    int         errors;

    risc_cpu dut (
        .clk      (clk),
        .rst      (rst),
        .data_out (data_out)
    );

    risc_cpu_if mon ();
    assign mon.addr  = dut.addr;
    assign mon.rdata = dut.mem_data;
    assign mon.wdata = dut.data_out;
    assign mon.wr    = dut.wr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance n rising edges and sample 1ns after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        step(3);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;

        // load/add/store program, loaded while reset is held
        dut.mem0.mem[5'h00] = 8'hBE;
        dut.mem0.mem[5'h01] = 8'h5F;
        dut.mem0.mem[5'h02] = 8'hC7;
        dut.mem0.mem[5'h03] = 8'h00;
        dut.mem0.mem[5'h07] = 8'h00;
        dut.mem0.mem[5'h1E] = 8'h05;
        dut.mem0.mem[5'h1F] = 8'h03;
        step(20);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_pc", {3'b0, dut.pc}, 8'h00);
        chk("rst_state", {5'b0, dut.ctrl0.state}, 8'h00);
        chk("rst_mem_kept", dut.mem0.mem[5'h00], 8'hBE);
        chk("rst_bus_addr", {3'b0, mon.addr}, 8'h00);
        rst = 1'b1;
        step(8);
        chk("lda_ac", data_out, 8'h05);
        step(8);
        chk("add_ac", data_out, 8'h08);
        step(8);
        chk("sto_mem7", dut.mem0.mem[5'h07], 8'h08);
        step(16);
        chk("hlt_state", {5'b0, dut.ctrl0.state}, 8'h04);
        chk("hlt_ac", data_out, 8'h08);
        chk("hlt_pc", {3'b0, dut.pc}, 8'h03);
        step(8);
        chk("hlt_state_held", {5'b0, dut.ctrl0.state}, 8'h04);

        // logic ops
        hold_reset();
        chk("rst2_ac", data_out, 8'h00);
        dut.mem0.mem[5'h00] = 8'hB0;
        dut.mem0.mem[5'h01] = 8'h71;
        dut.mem0.mem[5'h02] = 8'h92;
        dut.mem0.mem[5'h03] = 8'h53;
        dut.mem0.mem[5'h04] = 8'h00;
        dut.mem0.mem[5'h10] = 8'hF0;
        dut.mem0.mem[5'h11] = 8'h3C;
        dut.mem0.mem[5'h12] = 8'hFF;
        dut.mem0.mem[5'h13] = 8'h40;
        rst = 1'b1;
        step(8);
        chk("logic_lda", data_out, 8'hF0);
        step(8);
        chk("logic_and", data_out, 8'h30);
        step(8);
        chk("logic_xor", data_out, 8'hCF);
        step(8);
        chk("logic_add_wrap", data_out, 8'h0F);

        // SKZ taken with AC=0, not taken with AC!=0
        hold_reset();
        dut.mem0.mem[5'h00] = 8'hB0;
        dut.mem0.mem[5'h01] = 8'h20;
        dut.mem0.mem[5'h02] = 8'h00;
        dut.mem0.mem[5'h03] = 8'hB1;
        dut.mem0.mem[5'h04] = 8'h20;
        dut.mem0.mem[5'h05] = 8'h00;
        dut.mem0.mem[5'h06] = 8'hB2;
        dut.mem0.mem[5'h10] = 8'h00;
        dut.mem0.mem[5'h11] = 8'h55;
        dut.mem0.mem[5'h12] = 8'h77;
        rst = 1'b1;
        step(16);
        chk("skz_skip_pc", {3'b0, dut.pc}, 8'h03);
        step(8);
        chk("skz_continue_ac", data_out, 8'h55);
        step(26);
        chk("skz_noskip_state", {5'b0, dut.ctrl0.state}, 8'h04);
        chk("skz_noskip_pc", {3'b0, dut.pc}, 8'h05);
        chk("skz_noskip_ac", data_out, 8'h55);

        // JMP forward
        hold_reset();
        dut.mem0.mem[5'h00] = 8'hE5;
        dut.mem0.mem[5'h05] = 8'hBE;
        dut.mem0.mem[5'h06] = 8'h00;
        dut.mem0.mem[5'h1E] = 8'hA7;
        rst = 1'b1;
        step(8);
        chk("jmp_pc", {3'b0, dut.pc}, 8'h05);
        step(8);
        chk("jmp_lda_ac", data_out, 8'hA7);
        chk("jmp_pc_after", {3'b0, dut.pc}, 8'h06);

        // PC wrap 1F -> 00
        hold_reset();
        dut.mem0.mem[5'h00] = 8'hFF;
        dut.mem0.mem[5'h1F] = 8'hB0;
        dut.mem0.mem[5'h10] = 8'h3A;
        rst = 1'b1;
        step(8);
        chk("wrap_jmp_pc", {3'b0, dut.pc}, 8'h1F);
        step(8);
        chk("wrap_pc", {3'b0, dut.pc}, 8'h00);
        chk("wrap_ac", data_out, 8'h3A);

        // reset during state 6 of a STO
        hold_reset();
        dut.mem0.mem[5'h00] = 8'hB0;
        dut.mem0.mem[5'h01] = 8'hC8;
        dut.mem0.mem[5'h08] = 8'h11;
        dut.mem0.mem[5'h10] = 8'h99;
        rst = 1'b1;
        step(8);
        chk("sto_pre_ac", data_out, 8'h99);
        step(6);
        chk("sto_state6", {5'b0, dut.ctrl0.state}, 8'h06);
        rst = 1'b0;
        #1;
        chk("abort_ac", data_out, 8'h00);
        chk("abort_state", {5'b0, dut.ctrl0.state}, 8'h00);
        step(4);
        chk("abort_mem8", dut.mem0.mem[5'h08], 8'h11);
        chk("abort_pc", {3'b0, dut.pc}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
